// File: rtl/videocard_dispatcher_pkg.sv
// Shared definitions for the videocard job dispatcher: FSM state encoding,
// mailbox header layout and default mailbox geometry.
package videocard_dispatcher_pkg;

    // Dispatcher sequencing states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HDR      = 3'd1,
        ST_ARGS     = 3'd2,
        ST_RAISE    = 3'd3,
        ST_WAIT_ACK = 3'd4,
        ST_READ     = 3'd5,
        ST_WAIT_REL = 3'd6,
        ST_DONE     = 3'd7
    } state_t;

    // Interrupt number sits above the 16-bit argument count in the header word
    localparam int HDR_INT_LSB = 16;

    // Result area offset (words) from the mailbox header
    localparam int RES_OFFSET_DEFAULT = 16;

    // Mailbox header word address
    localparam logic [31:0] MAILBOX_BASE_DEFAULT = 32'h0000_F000;

    // Larger of two integers, used to size shared counters
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/videocard_dispatcher_bit_sync.sv
// Two-flop synchroniser for a single asynchronous level (interrupt_finish).
module videocard_dispatcher_bit_sync (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two register stages; the first may go metastable, the second is used
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/videocard_dispatcher.sv
// Host-side videocard job launcher. Writes a header and argument words into
// the shared mailbox, raises interrupt_start, waits for interrupt_finish,
// reads result words back, then completes the 4-phase handshake.
module videocard_dispatcher
    import videocard_dispatcher_pkg::*;
#(
    parameter int                 WIDTH        = 32,
    parameter int                 INT_NUM      = 3,
    parameter int                 ARG_NUM      = 8,
    parameter int                 RES_NUM      = 4,
    parameter logic [WIDTH-1:0]   MAILBOX_BASE = WIDTH'(MAILBOX_BASE_DEFAULT),
    parameter int                 RES_OFFSET   = RES_OFFSET_DEFAULT,
    parameter int                 TIMEOUT_W    = 20
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         job_valid,
    output logic                         job_ready,
    input  logic [INT_NUM-1:0]           job_int_num,
    input  logic [$clog2(ARG_NUM+1)-1:0] job_argc,
    input  logic                         arg_wr,
    input  logic [$clog2(ARG_NUM)-1:0]   arg_idx,
    input  logic [WIDTH-1:0]             arg_data,
    input  logic [$clog2(RES_NUM)-1:0]   res_idx,
    output logic [WIDTH-1:0]             res_data,
    output logic                         busy,
    output logic                         done,
    output logic                         timeout_err,
    output logic [WIDTH-1:0]             mem_address,
    output logic [WIDTH-1:0]             mem_writedata,
    output logic                         mem_wren,
    input  logic [WIDTH-1:0]             mem_readdata,
    output logic                         interrupt_start,
    input  logic                         interrupt_finish
);

    localparam int ARGC_W    = $clog2(ARG_NUM + 1);
    localparam int ARG_IDX_W = $clog2(ARG_NUM);
    localparam int RES_IDX_W = $clog2(RES_NUM);
    // One counter walks both the argument writes and the result reads
    localparam int CNT_W     = max_int(ARGC_W, $clog2(RES_NUM + 1));

    // Timer value one below all-ones: the edge leaving it lands on all-ones
    localparam logic [TIMEOUT_W-1:0] TIMER_LAST = {TIMEOUT_W{1'b1}} - TIMEOUT_W'(1);

    state_t                 state_q, state_d;
    logic [INT_NUM-1:0]     int_num_q, int_num_d;
    logic [ARGC_W-1:0]      argc_q, argc_d;
    logic [CNT_W-1:0]       idx_q, idx_d;
    logic [TIMEOUT_W-1:0]   timer_q, timer_d;
    logic                   start_q, start_d;
    logic                   timeout_err_q, timeout_err_d;

    logic                   fin_s;
    logic                   res_wr;
    logic [RES_IDX_W-1:0]   res_wr_idx;
    logic [WIDTH-1:0]       hdr_word;

    logic [WIDTH-1:0]       arg_buf [ARG_NUM];
    logic [WIDTH-1:0]       res_buf [RES_NUM];

    videocard_dispatcher_bit_sync u_fin_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (interrupt_finish),
        .q_o   (fin_s)
    );

    // Argument buffer: one register per slot, host writes only while idle
    for (genvar gi = 0; gi < ARG_NUM; gi++) begin : g_arg
        logic [WIDTH-1:0] word_q;

        // Capture host argument word into this slot
        always_ff @(posedge clk) begin
            if (arg_wr && !busy && (arg_idx == ARG_IDX_W'(gi))) begin
                word_q <= arg_data;
            end
        end

        assign arg_buf[gi] = word_q;
    end

    // Result buffer: one register per slot, filled during the readback phase
    for (genvar gi = 0; gi < RES_NUM; gi++) begin : g_res
        logic [WIDTH-1:0] word_q;

        // Capture the mailbox read data returned for this slot
        always_ff @(posedge clk) begin
            if (res_wr && (res_wr_idx == RES_IDX_W'(gi))) begin
                word_q <= mem_readdata;
            end
        end

        assign res_buf[gi] = word_q;
    end

    assign hdr_word   = (WIDTH'(int_num_q) << HDR_INT_LSB) | WIDTH'(argc_q);
    // Read data arriving now belongs to the address issued one cycle earlier
    assign res_wr_idx = RES_IDX_W'(idx_q - CNT_W'(1));

    // State and control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            int_num_q     <= '0;
            argc_q        <= '0;
            idx_q         <= '0;
            timer_q       <= '0;
            start_q       <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            int_num_q     <= int_num_d;
            argc_q        <= argc_d;
            idx_q         <= idx_d;
            timer_q       <= timer_d;
            start_q       <= start_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Next-state, mailbox bus and handshake decode
    always_comb begin
        state_d       = state_q;
        int_num_d     = int_num_q;
        argc_d        = argc_q;
        idx_d         = idx_q;
        timer_d       = timer_q;
        start_d       = start_q;
        timeout_err_d = timeout_err_q;
        res_wr        = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        mem_wren      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (job_valid && job_ready) begin
                    int_num_d     = job_int_num;
                    argc_d        = (job_argc > ARGC_W'(ARG_NUM)) ? ARGC_W'(ARG_NUM) : job_argc;
                    timeout_err_d = 1'b0;
                    idx_d         = '0;
                    state_d       = ST_HDR;
                end
            end

            ST_HDR: begin
                mem_wren      = 1'b1;
                mem_address   = MAILBOX_BASE;
                mem_writedata = hdr_word;
                idx_d         = '0;
                if (argc_q == '0) begin
                    start_d = 1'b1;
                    state_d = ST_RAISE;
                end else begin
                    state_d = ST_ARGS;
                end
            end

            ST_ARGS: begin
                mem_wren      = 1'b1;
                mem_address   = MAILBOX_BASE + WIDTH'(1) + WIDTH'(idx_q);
                mem_writedata = arg_buf[ARG_IDX_W'(idx_q)];
                idx_d         = idx_q + CNT_W'(1);
                if (idx_q == CNT_W'(argc_q) - CNT_W'(1)) begin
                    start_d = 1'b1;
                    state_d = ST_RAISE;
                end
            end

            ST_RAISE: begin
                timer_d = '0;
                state_d = ST_WAIT_ACK;
            end

            ST_WAIT_ACK: begin
                timer_d = timer_q + TIMEOUT_W'(1);
                if (fin_s) begin
                    idx_d   = '0;
                    state_d = ST_READ;
                end else if (timer_q == TIMER_LAST) begin
                    start_d       = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = ST_DONE;
                end
            end

            ST_READ: begin
                if (idx_q < CNT_W'(RES_NUM)) begin
                    mem_address = MAILBOX_BASE + WIDTH'(RES_OFFSET) + WIDTH'(idx_q);
                end
                res_wr = (idx_q != '0);
                idx_d  = idx_q + CNT_W'(1);
                if (idx_q == CNT_W'(RES_NUM)) begin
                    start_d = 1'b0;
                    timer_d = '0;
                    state_d = ST_WAIT_REL;
                end
            end

            ST_WAIT_REL: begin
                timer_d = timer_q + TIMEOUT_W'(1);
                if (!fin_s) begin
                    state_d = ST_DONE;
                end else if (timer_q == TIMER_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign job_ready       = (state_q == ST_IDLE) && !fin_s;
    assign busy            = (state_q != ST_IDLE);
    assign done            = (state_q == ST_DONE);
    assign timeout_err     = timeout_err_q;
    assign interrupt_start = start_q;
    assign res_data        = res_buf[res_idx];

endmodule

// File: tb/tb_videocard_dispatcher.sv
// Scoreboard bench for videocard_dispatcher: stimulus queues expected mailbox
// writes and done pulses, a negedge monitor pops and compares them.
module tb_videocard_dispatcher;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [2:0]  job_int_num = '0;
    logic [3:0]  job_argc = '0;
    logic        arg_wr = 1'b0;
    logic [2:0]  arg_idx = '0;
    logic [31:0] arg_data = '0;
    logic [1:0]  res_idx = '0;
    logic [31:0] res_data;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic [31:0] mem_address;
    logic [31:0] mem_writedata;
    logic        mem_wren;
    logic [31:0] mem_readdata = '0;
    logic        interrupt_start;
    logic        interrupt_finish = 1'b0;

    videocard_dispatcher #(
        .TIMEOUT_W (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .job_valid        (job_valid),
        .job_ready        (job_ready),
        .job_int_num      (job_int_num),
        .job_argc         (job_argc),
        .arg_wr           (arg_wr),
        .arg_idx          (arg_idx),
        .arg_data         (arg_data),
        .res_idx          (res_idx),
        .res_data         (res_data),
        .busy             (busy),
        .done             (done),
        .timeout_err      (timeout_err),
        .mem_address      (mem_address),
        .mem_writedata    (mem_writedata),
        .mem_wren         (mem_wren),
        .mem_readdata     (mem_readdata),
        .interrupt_start  (interrupt_start),
        .interrupt_finish (interrupt_finish)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Mailbox memory model: word = {BEEF, low address} ^ salt, one-cycle latency
    logic [31:0] salt = '0;
    always @(posedge clk) mem_readdata <= {16'hBEEF, mem_address[15:0]} ^ salt;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    function automatic void fail_evt(input string name, input string what);
        n_checks++;
        $display("FAIL %s: got %s", name, what);
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t  wr_q[$];
    logic done_q[$];
    wr_t  mon_w;
    logic mon_d;

    logic [31:0] model_args [8];
    logic [31:0] model_res  [4];

    // Monitor: every mailbox write and done pulse is matched to the scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_wren) begin
                if (wr_q.size() == 0) begin
                    fail_evt("unexpected_write", $sformatf("write %h=%h, expected none", mem_address, mem_writedata));
                end else begin
                    mon_w = wr_q.pop_front();
                    check("wr_addr", mem_address, mon_w.addr);
                    check("wr_data", mem_writedata, mon_w.data);
                    check("wr_cycle", 32'(cyc), 32'(mon_w.cyc));
                    $display("write  cyc=%0d addr=%h data=%h", cyc, mem_address, mem_writedata);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    fail_evt("unexpected_done", "done pulse, expected none");
                end else begin
                    mon_d = done_q.pop_front();
                    check("done_timeout_err", 32'(timeout_err), 32'(mon_d));
                    $display("done   cyc=%0d timeout_err=%0b", cyc, timeout_err);
                end
            end
        end
    end

    task automatic write_arg(input int i, input logic [31:0] d);
        @(negedge clk);
        arg_wr   = 1'b1;
        arg_idx  = i[2:0];
        arg_data = d;
        if (!busy) model_args[i] = d;
        @(negedge clk);
        arg_wr = 1'b0;
    endtask

    // mode 0: full handshake, 1: ack timeout, 2: reset while waiting for ack
    task automatic run_job(input logic [2:0] inum, input int argc, input int mode,
                           input logic [31:0] new_salt, input bit poke);
        int   n;
        int   acc;
        int   s;
        int   e;
        int   f;
        int   g;
        wr_t  w;
        logic [31:0] exp_res;
        n = (argc > 8) ? 8 : argc;
        @(negedge clk);
        check("job_ready_idle", 32'(job_ready), 32'd1);
        salt = new_salt;
        acc  = cyc;
        w.addr = 32'h0000_F000;
        w.data = (32'(inum) << 16) | 32'(n);
        w.cyc  = acc + 1;
        wr_q.push_back(w);
        for (int i = 0; i < n; i++) begin
            w.addr = 32'h0000_F001 + 32'(i);
            w.data = model_args[i];
            w.cyc  = acc + 2 + i;
            wr_q.push_back(w);
        end
        if (mode != 2) done_q.push_back(mode == 1);
        job_valid   = 1'b1;
        job_int_num = inum;
        job_argc    = argc[3:0];
        @(negedge clk);
        job_valid = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
        check("timeout_err_cleared", 32'(timeout_err), 32'd0);
        if (poke) begin
            arg_wr   = 1'b1;
            arg_idx  = 3'd0;
            arg_data = 32'hDEAD_BEEF;
            @(negedge clk);
            arg_wr = 1'b0;
        end
        s = -1;
        for (int k = 0; k < 40 && s < 0; k++) begin
            if (interrupt_start) s = cyc;
            else @(negedge clk);
        end
        if (s < 0) begin
            fail_evt("start_rise", "no interrupt_start within 40 cycles");
            return;
        end
        check("start_rise_cycle", 32'(s), 32'(acc + n + 2));
        $display("start  cyc=%0d argc=%0d", s, argc);

        if (mode == 2) begin
            @(negedge clk);
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            check("rst_start", 32'(interrupt_start), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            reset = 1'b0;
            $display("reset  cyc=%0d mid-job", cyc);
        end else if (mode == 1) begin
            e = -1;
            for (int k = 0; k < 40 && e < 0; k++) begin
                if (!interrupt_start) e = cyc;
                else @(negedge clk);
            end
            check("timeout_start_fall", 32'(e), 32'(s + 16));
            check("timeout_err_set", 32'(timeout_err), 32'd1);
            check("timeout_done", 32'(done), 32'd1);
            for (int i = 0; i < 4; i++) begin
                res_idx = i[1:0];
                #1;
                check("res_kept_on_timeout", res_data, model_res[i]);
            end
            @(negedge clk);
            check("timeout_err_held", 32'(timeout_err), 32'd1);
            check("idle_after_timeout", 32'(busy), 32'd0);
        end else begin
            repeat (10) @(posedge clk);
            #1;
            interrupt_finish = 1'b1;
            f = cyc;
            e = -1;
            for (int k = 0; k < 40 && e < 0; k++) begin
                @(negedge clk);
                if (!interrupt_start) e = cyc;
            end
            check("start_fall_cycle", 32'(e), 32'(f + 8));
            for (int i = 0; i < 4; i++) begin
                exp_res = {16'hBEEF, 16'hF010 + 16'(i)} ^ salt;
                model_res[i] = exp_res;
                res_idx = i[1:0];
                #1;
                check("res_data", res_data, exp_res);
            end
            @(posedge clk);
            #1;
            interrupt_finish = 1'b0;
            g = cyc;
            e = -1;
            for (int k = 0; k < 40 && e < 0; k++) begin
                @(negedge clk);
                if (done) e = cyc;
            end
            check("done_cycle", 32'(e), 32'(g + 3));
            @(negedge clk);
            check("idle_after_done", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_job_ready", 32'(job_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_timeout_err", 32'(timeout_err), 32'd0);
        check("reset_start", 32'(interrupt_start), 32'd0);
        check("reset_wren", 32'(mem_wren), 32'd0);
        check("reset_addr", mem_address, 32'd0);
        check("reset_wdata", mem_writedata, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) write_arg(i, 32'h1000_0000 + 32'(i));
        write_arg(0, 32'hA0A0_0001);
        write_arg(1, 32'hA1A1_0002);
        for (int i = 0; i < 4; i++) model_res[i] = '0;

        // argc=2, int_num=5: header 0x0005_0002, start at c4, full handshake
        run_job(3'd5, 2, 0, 32'h0000_0000, 1'b0);
        // argc=0: header only, start at c2
        run_job(3'd3, 0, 0, 32'h0000_1111, 1'b0);
        // argc=12 clamps to 8
        run_job(3'd7, 12, 0, 32'h2222_0000, 1'b0);
        // finish never rises: timeout after 15 WAIT_ACK cycles, results untouched
        run_job(3'd1, 3, 1, 32'h3333_3333, 1'b0);
        // next accept clears timeout_err
        run_job(3'd2, 1, 0, 32'h0000_0044, 1'b0);
        // reset while waiting for ack
        run_job(3'd4, 1, 2, 32'h0000_0000, 1'b0);

        // finish held high while idle blocks acceptance and starts nothing
        @(negedge clk);
        interrupt_finish = 1'b1;
        repeat (3) @(negedge clk);
        check("fin_blocks_ready", 32'(job_ready), 32'd0);
        job_valid = 1'b1;
        @(negedge clk);
        job_valid = 1'b0;
        check("fin_no_accept", 32'(busy), 32'd0);
        interrupt_finish = 1'b0;
        repeat (3) @(negedge clk);
        check("ready_after_fin_low", 32'(job_ready), 32'd1);
        $display("idle   cyc=%0d finish-glitch test", cyc);

        // arg_wr while busy is ignored; the following job sends the old slot 0
        run_job(3'd6, 2, 1, 32'h0000_0005, 1'b1);
        run_job(3'd6, 2, 0, 32'h0000_0006, 1'b0);

        repeat (5) @(negedge clk);
        check("writes_outstanding", 32'(wr_q.size()), 32'd0);
        check("dones_outstanding", 32'(done_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
